// File: rtl/lsu_data_mem_pkg.sv
// Shared definitions for the load/store unit.
// Contains the funct3 access-size codes, the FSM state encoding, the width of
// the timeout counter, the captured-request context and a byte-lane helper.
package lsu_data_mem_pkg;

    // funct3 access-size / sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for the full TIMEOUT_CYCLES range (1..65535)
    localparam int unsigned TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Request context kept for the whole access
    typedef struct packed {
        logic       is_load;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lsu_ctx_t;

    // Byte enables for an access of the given size at the given byte offset
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'(4'b0001 << off);
            2'b01:   m = 4'(4'b0011 << off);
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment for the load/store unit.
// Shifts the addressed lane of the memory word down to bit 0 and applies
// sign or zero extension according to funct3.
//   mem_rdata  in  32  raw word from data memory
//   offset     in  2   byte offset of the access (addr[1:0])
//   funct3     in  3   access size/sign code
//   result_c   out 32  aligned, extended load value (combinational)
module lsu_load_align
    import lsu_data_mem_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result_c
);

    logic [31:0] shifted;

    // Move the addressed byte lane down to bit 0
    assign shifted = mem_rdata >> {offset, 3'b000};

    always_comb begin
        result_c = '0;
        case (funct3)
            F3_B:    result_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result_c = mem_rdata;
            F3_BU:   result_c = {24'h000000, shifted[7:0]};
            F3_HU:   result_c = {16'h0000, shifted[15:0]};
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store unit for the MEM stage.
// Accepts a load or store from the pipeline, drives a req/ack data-memory bus
// with byte enables and lane-replicated store data, aligns and extends load
// data, and stalls the pipeline until the access completes or faults.
//   clk, rst             clock, asynchronous active-high reset
//   MemRead, MemWrite    load / store request, sampled in IDLE
//   funct3, addr, wdata  access size/sign, byte address, store data
//   stall                pipeline hold, combinational: busy or accepting
//   done, fault          one-cycle completion pulse and its fault flag
//   load_data            aligned load result, held until the next done
//   mem_req .. mem_wdata data-memory request bus, held until mem_ack
//   mem_ack, mem_rdata   data-memory completion pulse and read data
module lsu_data_mem
    import lsu_data_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_t        state;
    lsu_ctx_t          ctx;
    logic [TMO_W-1:0]  tmo_cnt;

    logic        accept;
    logic        f3_legal;
    logic        misaligned;
    logic        accept_fault;
    logic        tmo_hit;
    logic [31:0] wdata_rep;
    logic [31:0] aligned_c;

    assign accept = (state == IDLE) && (MemRead || MemWrite);
    assign stall  = (state != IDLE) || accept;

    // Legal funct3 codes; the unsigned variants exist only for loads
    always_comb begin
        f3_legal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !MemWrite;
            default:          f3_legal = 1'b0;
        endcase
    end

    // Halfwords need 2-byte alignment, words 4-byte alignment
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign accept_fault = (MemRead && MemWrite) || !f3_legal || misaligned;

    // Replicate store data across all lanes so any enabled lane sees it
    always_comb begin
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00:   wdata_rep = {4{wdata[7:0]}};
            2'b01:   wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    // Last REQ cycle allowed before the access is abandoned
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .offset    (ctx.offset),
        .funct3    (ctx.funct3),
        .result_c  (aligned_c)
    );

    // Access FSM with capture registers, timeout counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctx       <= '0;
            tmo_cnt   <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            load_data <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (accept) begin
                        if (accept_fault) begin
                            // Rejected without touching the bus
                            state     <= RESP;
                            done      <= 1'b1;
                            fault     <= 1'b1;
                            load_data <= '0;
                        end else begin
                            state       <= REQ;
                            tmo_cnt     <= '0;
                            ctx.is_load <= MemRead;
                            ctx.funct3  <= funct3;
                            ctx.offset  <= addr[1:0];
                            mem_req     <= 1'b1;
                            mem_we      <= MemWrite;
                            mem_addr    <= {addr[31:2], 2'b00};
                            mem_be      <= lane_mask(funct3, addr[1:0]);
                            mem_wdata   <= MemWrite ? wdata_rep : 32'h0;
                        end
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        // Ack wins over a timeout in the same cycle
                        state   <= RESP;
                        tmo_cnt <= '0;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b0;
                        if (ctx.is_load) begin
                            load_data <= aligned_c;
                        end
                    end else if (tmo_hit) begin
                        state     <= RESP;
                        tmo_cnt   <= '0;
                        mem_req   <= 1'b0;
                        done      <= 1'b1;
                        fault     <= 1'b1;
                        load_data <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                RESP: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
